cpu5_mc_ctrl: RTL
=================

Name: cpu5_mc_ctrl

Overview:
Multicycle control FSM for the cpu5 core, replacing the single-cycle main decoder when the core runs in multicycle mode over one shared instruction/data memory port. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write enables, and runs a req/ack handshake with a memory that may insert wait states. An unsupported opcode raises a one-cycle trap pulse.

Parameters:
OPCODE_SIZE, 6, width of instruction opcode field (matches CPU5_OPCODE_SIZE)
ALUOP_SIZE, 2, width of aluop to ALU decoder (matches CPU5_ALU_OP_SIZE)

Ports:
clk  input  1  core clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces state to S_FETCH
op  input  OPCODE_SIZE  opcode from instruction register (valid from S_DECODE on)
mem_ack  input  1  memory completes the current request this cycle
mem_req  output  1  memory request, held high until mem_ack
memwrite  output  1  request is a write (valid only with mem_req)
iord  output  1  memory address select: 0=PC, 1=ALUOut
irwrite  output  1  load instruction register
mdrwrite  output  1  load memory data register
pcwrite  output  1  unconditional PC write
pcwrite_cond  output  1  PC write if ALU zero (beq)
pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
alusrca  output  1  0=PC, 1=rs register
alusrcb  output  2  00=rt, 01=constant 4, 10=signext imm, 11=signext imm<<2
aluop  output  ALUOP_SIZE  00=add, 01=sub, 10=funct field
regwrite  output  1  register file write enable
regdst  output  1  0=rt, 1=rd
memtoreg  output  1  0=ALUOut, 1=MDR
trap  output  1  one-cycle pulse, illegal opcode

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010; all other opcodes are illegal.
- States (one-hot or binary, implementer's choice): S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP.
- Outputs are Moore (a function of state only), except the ack-gated enables below. Unlisted outputs are 0 in every state.
- S_FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ack. Stay while !mem_ack, otherwise go to S_DECODE.
- S_DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target to ALUOut). Next state: LW/SW -> S_MEMADR; RTYPE -> S_EXEC; BEQ -> S_BRANCH; ADDI -> S_ADDIEX; J -> S_JUMP; illegal -> S_TRAP.
- S_MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: LW -> S_MEMRD, SW -> S_MEMWR.
- S_MEMRD: mem_req=1, iord=1, mdrwrite=mem_ack. Stay until mem_ack, then go to S_MEMWB.
- S_MEMWB: regwrite=1, regdst=0, memtoreg=1. Next state is S_FETCH.
- S_MEMWR: mem_req=1, memwrite=1, iord=1. Stay until mem_ack, then go to S_FETCH.
- S_EXEC: alusrca=1, alusrcb=00, aluop=10. Next state is S_ALUWB.
- S_ALUWB: regwrite=1, regdst=1, memtoreg=0. Next state is S_FETCH.
- S_BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcwrite_cond=1. Next state is S_FETCH.
- S_ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state is S_ADDIWB.
- S_ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next state is S_FETCH.
- S_JUMP: pcwrite=1, pcsrc=10. Next state is S_FETCH.
- S_TRAP: trap=1 for exactly one cycle; no regwrite, pcwrite or mem_req. Next state is S_FETCH. PC has already advanced by 4.
- Latency with zero wait states: LW 5 cycles; SW, RTYPE and ADDI 4; BEQ and J 3; illegal 3. Each wait cycle (mem_ack low while mem_req high) adds 1 cycle.
- Handshake: mem_req, memwrite and iord are held stable while waiting. mem_ack is ignored whenever mem_req=0. op is sampled only in S_DECODE and S_MEMADR.
- Reset: synchronous. At the clock edge with reset=1 the state becomes S_FETCH, regardless of current state, including mid-wait in S_MEMRD or S_MEMWR. The first cycle after reset shows S_FETCH outputs: mem_req=1, iord=0, alusrcb=01, and all enables 0 unless mem_ack=1.
- An abandoned memory transaction is not cancelled; the memory must accept a new request without an intervening idle cycle.
- reset and mem_ack high in the same cycle: reset wins, and the state becomes S_FETCH.

Test Plan:
- Reset, then LW (op=100011) with mem_ack high every request cycle -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. irwrite and pcwrite pulse in cycle 1, mdrwrite in cycle 4, regwrite=1 and memtoreg=1 in cycle 5, back in FETCH at cycle 6.
- SW with mem_ack delayed 3 cycles in S_MEMWR -> mem_req=1, memwrite=1, iord=1 held stable for 4 cycles, no regwrite, FETCH follows the ack cycle.
- BEQ (000100) -> 3 cycles. S_BRANCH shows aluop=01, pcsrc=01, pcwrite_cond=1, and pcwrite=0.
- RTYPE then ADDI back to back -> RTYPE shows regdst=1 and aluop=10 (4 cycles). ADDI shows alusrcb=10 and regdst=0 (4 cycles). There are no idle cycles between instructions.
- Illegal op=111111 -> trap high for exactly one cycle after DECODE, with no regwrite, pcwrite or mem_req in that cycle, then FETCH.
- Reset asserted during S_MEMRD wait (mem_ack=0) -> next cycle in S_FETCH with iord=0 and mdrwrite never asserted. A J (000010) run afterwards shows pcwrite=1 and pcsrc=10 in cycle 3.

Source files
------------

// File: rtl/cpu5_mc_ctrl.sv
// ============================================================================
// Module      : cpu5_mc_ctrl
// Description : Multicycle control FSM for the cpu5 core sharing a single
//               instruction/data memory port with a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu5_mc_ctrl #(
    parameter int OPCODE_SIZE = 6,
    parameter int ALUOP_SIZE  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODE_SIZE-1:0] op,
    input  logic                   mem_ack,
    output logic                   mem_req,
    output logic                   memwrite,
    output logic                   iord,
    output logic                   irwrite,
    output logic                   mdrwrite,
    output logic                   pcwrite,
    output logic                   pcwrite_cond,
    output logic [1:0]             pcsrc,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [ALUOP_SIZE-1:0]  aluop,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   trap
);

    localparam logic [OPCODE_SIZE-1:0] c_OP_RTYPE = OPCODE_SIZE'(6'b000000);
    localparam logic [OPCODE_SIZE-1:0] c_OP_LW    = OPCODE_SIZE'(6'b100011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_SW    = OPCODE_SIZE'(6'b101011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_BEQ   = OPCODE_SIZE'(6'b000100);
    localparam logic [OPCODE_SIZE-1:0] c_OP_ADDI  = OPCODE_SIZE'(6'b001000);
    localparam logic [OPCODE_SIZE-1:0] c_OP_J     = OPCODE_SIZE'(6'b000010);

    localparam logic [ALUOP_SIZE-1:0] c_ALU_ADD   = ALUOP_SIZE'(2'b00);
    localparam logic [ALUOP_SIZE-1:0] c_ALU_SUB   = ALUOP_SIZE'(2'b01);
    localparam logic [ALUOP_SIZE-1:0] c_ALU_FUNCT = ALUOP_SIZE'(2'b10);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_mem_req;
    logic                  r_memwrite;
    logic                  r_iord;
    logic                  r_pcwrite;
    logic                  r_pcwrite_cond;
    logic [1:0]            r_pcsrc;
    logic                  r_alusrca;
    logic [1:0]            r_alusrcb;
    logic [ALUOP_SIZE-1:0] r_aluop;
    logic                  r_regwrite;
    logic                  r_regdst;
    logic                  r_memtoreg;
    logic                  r_trap;
    logic                  r_in_fetch;
    logic                  r_in_memrd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == c_OP_LW || op == c_OP_SW) w_next = S_MEMADR;
                else if (op == c_OP_RTYPE)          w_next = S_EXEC;
                else if (op == c_OP_BEQ)            w_next = S_BRANCH;
                else if (op == c_OP_ADDI)           w_next = S_ADDIEX;
                else if (op == c_OP_J)              w_next = S_JUMP;
                else                                w_next = S_TRAP;
            end
            S_MEMADR: w_next = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ack ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ack ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore outputs are registered from the state being entered, so they
    // change together with r_state and carry no decode glitches.
    always_ff @(posedge clk) begin
        r_mem_req      <= 1'b0;
        r_memwrite     <= 1'b0;
        r_iord         <= 1'b0;
        r_pcwrite      <= 1'b0;
        r_pcwrite_cond <= 1'b0;
        r_pcsrc        <= 2'b00;
        r_alusrca      <= 1'b0;
        r_alusrcb      <= 2'b00;
        r_aluop        <= c_ALU_ADD;
        r_regwrite     <= 1'b0;
        r_regdst       <= 1'b0;
        r_memtoreg     <= 1'b0;
        r_trap         <= 1'b0;
        r_in_fetch     <= 1'b0;
        r_in_memrd     <= 1'b0;
        if (reset) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_alusrcb  <= 2'b01;
            r_in_fetch <= 1'b1;
        end else begin
            r_state <= w_next;
            case (w_next)
                S_FETCH: begin
                    r_mem_req  <= 1'b1;
                    r_alusrcb  <= 2'b01;
                    r_in_fetch <= 1'b1;
                end
                S_DECODE: r_alusrcb <= 2'b11;
                S_MEMADR: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                S_MEMRD: begin
                    r_mem_req  <= 1'b1;
                    r_iord     <= 1'b1;
                    r_in_memrd <= 1'b1;
                end
                S_MEMWB: begin
                    r_regwrite <= 1'b1;
                    r_memtoreg <= 1'b1;
                end
                S_MEMWR: begin
                    r_mem_req  <= 1'b1;
                    r_memwrite <= 1'b1;
                    r_iord     <= 1'b1;
                end
                S_EXEC: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= c_ALU_FUNCT;
                end
                S_ALUWB: begin
                    r_regwrite <= 1'b1;
                    r_regdst   <= 1'b1;
                end
                S_BRANCH: begin
                    r_alusrca      <= 1'b1;
                    r_aluop        <= c_ALU_SUB;
                    r_pcsrc        <= 2'b01;
                    r_pcwrite_cond <= 1'b1;
                end
                S_ADDIEX: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                S_ADDIWB: r_regwrite <= 1'b1;
                S_JUMP: begin
                    r_pcwrite <= 1'b1;
                    r_pcsrc   <= 2'b10;
                end
                S_TRAP:  r_trap <= 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign memwrite     = r_memwrite;
    assign iord         = r_iord;
    assign irwrite      = r_in_fetch & mem_ack;
    assign mdrwrite     = r_in_memrd & mem_ack;
    assign pcwrite      = r_pcwrite | (r_in_fetch & mem_ack);
    assign pcwrite_cond = r_pcwrite_cond;
    assign pcsrc        = r_pcsrc;
    assign alusrca      = r_alusrca;
    assign alusrcb      = r_alusrcb;
    assign aluop        = r_aluop;
    assign regwrite     = r_regwrite;
    assign regdst       = r_regdst;
    assign memtoreg     = r_memtoreg;
    assign trap         = r_trap;

endmodule

`default_nettype wire
